stream_capture_buffer: RTL



---
 rtl/stream_capture_buffer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/stream_capture_buffer.sv
// Trigger-armed snapshot of the concatenated link word into on-chip RAM,
// replayed in write order over an AXI-Stream master.
// Ports: clk, reset (sync, active-high); data_in/data_valid input word;
//   arm, trigger, abort, capture_len control; M_AXIS_* readout stream;
//   state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT); done completion pulse.
module stream_capture_buffer #(
    parameter int N_LINKS    = 12,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_LINKS*DATA_WIDTH-1:0] data_in,
    input  logic                          data_valid,
    input  logic                          arm,
    input  logic                          trigger,
    input  logic                          abort,
    input  logic [ADDR_W:0]               capture_len,
    output logic [N_LINKS*DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TLAST,
    output logic [1:0]                    state,
    output logic                          done
);
    localparam int W = N_LINKS * DATA_WIDTH;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            pend_q, pend_d;
    logic            pend_last_q, pend_last_d;
    logic            out_v_q, out_v_d;
    logic            out_last_q, out_last_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            sk_v_q, sk_v_d;
    logic            sk_last_q, sk_last_d;
    logic [W-1:0]    sk_data_q, sk_data_d;
    logic            done_q, done_d;

    logic [W-1:0]    mem [DEPTH];
    logic [W-1:0]    rd_data_q;
    logic            wr_en;
    logic            issue;
    logic            pop;
    logic            last_wr;
    logic [1:0]      occ;
    logic            room;
    logic [ADDR_W:0] len_clamped;

    assign len_clamped = (capture_len == '0 || capture_len > DEPTH_C)
                         ? DEPTH_C : capture_len;
    assign last_wr = (wr_ptr_q == len_q - ONE);
    assign pop     = out_v_q & M_AXIS_TREADY;
    // Words already owned by the output pipeline, including the RAM read
    // in flight; at most two may be held (output register + skid).
    assign occ     = 2'(out_v_q) + 2'(sk_v_q) + 2'(pend_q);
    assign room    = (occ - 2'(pop)) < 2'd2;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
        out_v_d     = out_v_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        sk_v_d      = sk_v_q;
        sk_last_d   = sk_last_q;
        sk_data_d   = sk_data_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        issue       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d  = S_ARMED;
                    len_d    = len_clamped;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            S_ARMED: begin
                if (trigger) begin
                    state_d = S_CAPTURE;
                    if (data_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE;
                        if (last_wr) begin
                            state_d  = S_READOUT;
                            wr_ptr_d = '0;
                        end
                    end
                end
            end
            S_CAPTURE: begin
                if (data_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE;
                    if (last_wr) begin
                        state_d  = S_READOUT;
                        wr_ptr_d = '0;
                    end
                end
            end
            S_READOUT: begin
                issue = (rd_ptr_q != len_q) && room;
                if (pop && out_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            rd_ptr_d    = rd_ptr_q + ONE;
            pend_d      = 1'b1;
            pend_last_d = (rd_ptr_q == len_q - ONE);
        end

        // Returning RAM word goes to the output register when it is free
        // (or being consumed), otherwise parks in the skid register.
        if (pop) begin
            if (sk_v_q) begin
                out_v_d    = 1'b1;
                out_last_d = sk_last_q;
                out_data_d = sk_data_q;
                sk_v_d     = pend_q;
                sk_last_d  = pend_last_q;
                sk_data_d  = rd_data_q;
            end else begin
                out_v_d    = pend_q;
                out_last_d = pend_last_q;
                out_data_d = rd_data_q;
            end
        end else if (pend_q) begin
            if (out_v_q) begin
                sk_v_d    = 1'b1;
                sk_last_d = pend_last_q;
                sk_data_d = rd_data_q;
            end else begin
                out_v_d    = 1'b1;
                out_last_d = pend_last_q;
                out_data_d = rd_data_q;
            end
        end

        if (abort) begin
            state_d = S_IDLE;
            wr_en   = 1'b0;
            pend_d  = 1'b0;
            out_v_d = 1'b0;
            sk_v_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= DEPTH_C;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            out_v_q     <= 1'b0;
            out_last_q  <= 1'b0;
            sk_v_q      <= 1'b0;
            sk_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            out_v_q     <= out_v_d;
            out_last_q  <= out_last_d;
            sk_v_q      <= sk_v_d;
            sk_last_q   <= sk_last_d;
            done_q      <= done_d;
        end
    end

    // Data path and RAM carry no reset; validity lives in the flags above.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
        sk_data_q  <= sk_data_d;
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= data_in;
        end
        rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
    end

    assign M_AXIS_TDATA  = out_data_q;
    assign M_AXIS_TVALID = out_v_q;
    assign M_AXIS_TLAST  = out_v_q & out_last_q;
    assign state         = state_q;
    assign done          = done_q;
endmodule
